// File: rtl/cw305_reg_arb_if.sv
// Burst-master port of the CW305 register arbiter.
// The burst engine owns the master side, the arbiter the slave side.
interface cw305_reg_arb_if #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7
);
  localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;

  logic                   m_req;
  logic                   m_gnt;
  logic                   m_wr;
  logic [AW-1:0]          m_address;
  logic [pBYTECNT_SIZE:0] m_len;
  logic [7:0]             m_wdata;
  logic                   m_wdata_rd;
  logic [7:0]             m_rdata;
  logic                   m_rdata_valid;
  logic                   m_done;
  logic                   m_abort;

  modport master (
    output m_req, m_wr, m_address, m_len,
    output m_wdata, m_abort,
    input  m_gnt, m_wdata_rd, m_rdata,
    input  m_rdata_valid, m_done
  );

  modport slave (
    input  m_req, m_wr, m_address, m_len,
    input  m_wdata, m_abort,
    output m_gnt, m_wdata_rd, m_rdata,
    output m_rdata_valid, m_done
  );
endinterface

// File: rtl/cw305_reg_arb.sv
// CW305 register-bus arbiter: host pass-through with absolute priority,
// internal bursts issued one byte at a time in host-idle gaps.
module cw305_reg_arb #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pHOLDOFF      = 4
) (
  input  logic usb_clk,
  input  logic rst_n,

  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] h_address,
  input  logic [pBYTECNT_SIZE-1:0]             h_bytecnt,
  input  logic [7:0]                           h_datao,
  input  logic                                 h_read,
  input  logic                                 h_write,
  output logic [7:0]                           h_datai,

  cw305_reg_arb_if.slave m,

  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  output logic [7:0]                           reg_datao,
  input  logic [7:0]                           reg_datai,
  output logic                                 reg_read,
  output logic                                 reg_write,
  output logic                                 reg_addrvalid
);
  localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int BW = pBYTECNT_SIZE;
  localparam int LW = pBYTECNT_SIZE + 1;
  localparam logic [LW-1:0] MAXLEN = LW'(2 ** BW);

  typedef enum logic [2:0] {
    IDLE, LOAD, ISSUE, CAPT, DONE
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      idle_cnt;
  logic [LW-1:0]   idx, len, len_clamp;
  logic [AW-1:0]   addr;
  logic            wr;
  logic            h_act, hgap, last;
  logic            fsm_rd, fsm_wr, sel_fsm;

  assign h_act = h_read | h_write;
  assign hgap  = (idle_cnt == 4'(pHOLDOFF)) & ~h_act;
  assign last  = (idx == len - LW'(1));

  assign len_clamp = (m.m_len > MAXLEN) ? MAXLEN : m.m_len;

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    m.m_gnt   = 1'b0;
    m.m_done  = 1'b0;
    fsm_rd    = 1'b0;
    fsm_wr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (m.m_req) state_nxt = LOAD;
      end
      LOAD: begin
        m.m_gnt = 1'b1;
        if (m.m_abort)            state_nxt = IDLE;
        else if (len_clamp == '0) state_nxt = DONE;
        else                      state_nxt = ISSUE;
      end
      ISSUE: begin
        if (m.m_abort) begin
          state_nxt = IDLE;
        end else if (hgap) begin
          if (wr) begin
            fsm_wr = 1'b1;
            if (last) state_nxt = DONE;
          end else begin
            fsm_rd    = 1'b1;
            state_nxt = CAPT;
          end
        end
      end
      CAPT: begin
        if (m.m_abort) state_nxt = IDLE;
        else if (last) state_nxt = DONE;
        else           state_nxt = ISSUE;
      end
      DONE: begin
        m.m_done  = 1'b1;
        state_nxt = m.m_req ? LOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (h_act) begin
      idle_cnt <= '0;
    end else if (idle_cnt != 4'(pHOLDOFF)) begin
      idle_cnt <= idle_cnt + 4'd1;
    end
  end

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      len  <= '0;
      addr <= '0;
      wr   <= 1'b0;
    end else if (state == LOAD) begin
      idx  <= '0;
      len  <= len_clamp;
      addr <= m.m_address;
      wr   <= m.m_wr;
    end else if (fsm_wr || (state == CAPT && !m.m_abort)) begin
      idx  <= idx + LW'(1);
    end
  end

  // Read data was latched by the register block on the reg_read cycle,
  // so the capture stands even when the host returns or an abort lands.
  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      m.m_rdata       <= '0;
      m.m_rdata_valid <= 1'b0;
    end else begin
      m.m_rdata_valid <= (state == CAPT);
      if (state == CAPT) m.m_rdata <= reg_datai;
    end
  end

  assign sel_fsm = fsm_rd | fsm_wr;

  assign reg_address   = sel_fsm ? addr          : h_address;
  assign reg_bytecnt   = sel_fsm ? idx[BW-1:0]   : h_bytecnt;
  assign reg_datao     = sel_fsm ? m.m_wdata     : h_datao;
  assign reg_read      = sel_fsm ? fsm_rd        : h_read;
  assign reg_write     = sel_fsm ? fsm_wr        : h_write;
  assign reg_addrvalid = reg_read | reg_write;

  assign m.m_wdata_rd = fsm_wr;
  assign h_datai      = reg_datai;
endmodule

// File: tb/tb_cw305_reg_arb.sv
// Directed bench for cw305_reg_arb: host pass-through, bursts,
// host collisions, length limits, abort and async reset.
module tb_cw305_reg_arb;
  localparam int AW = 14;
  localparam int BW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] h_address = '0;
  logic [BW-1:0] h_bytecnt = '0;
  logic [7:0]    h_datao = '0;
  logic          h_read = 1'b0;
  logic          h_write = 1'b0;
  logic [7:0]    h_datai;
  logic [AW-1:0] reg_address;
  logic [BW-1:0] reg_bytecnt;
  logic [7:0]    reg_datao;
  logic [7:0]    reg_datai = '0;
  logic          reg_read, reg_write, reg_addrvalid;
  logic [7:0]    wptr = '0;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int wdrd_n = 0;
  int gnt_q[$], done_q[$];
  int rd_cyc[$], rd_bc[$], rd_adr[$];
  int wr_cyc[$], wr_bc[$], wr_dat[$];
  int rv_cyc[$], rv_dat[$];

  cw305_reg_arb_if #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(7)) mif ();

  cw305_reg_arb #(
    .pADDR_WIDTH(21), .pBYTECNT_SIZE(7), .pHOLDOFF(4)
  ) dut (
    .usb_clk(clk), .rst_n(rst_n),
    .h_address(h_address), .h_bytecnt(h_bytecnt),
    .h_datao(h_datao), .h_read(h_read),
    .h_write(h_write), .h_datai(h_datai),
    .m(mif),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
    .reg_datao(reg_datao), .reg_datai(reg_datai),
    .reg_read(reg_read), .reg_write(reg_write),
    .reg_addrvalid(reg_addrvalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register block answers the cycle after reg_read; FWFT write source.
  always @(posedge clk) begin
    if (reg_read) reg_datai <= 8'h10 + 8'(reg_bytecnt);
    if (mif.m_wdata_rd) wptr <= wptr + 8'd1;
  end
  assign mif.m_wdata = 8'hC0 + wptr;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mif.m_gnt) gnt_q.push_back(cyc);
      if (mif.m_done) done_q.push_back(cyc);
      if (mif.m_wdata_rd) wdrd_n++;
      if (mif.m_rdata_valid) begin
        rv_cyc.push_back(cyc);
        rv_dat.push_back(int'(mif.m_rdata));
      end
      if (!(h_read || h_write) && reg_read) begin
        rd_cyc.push_back(cyc);
        rd_bc.push_back(int'(reg_bytecnt));
        rd_adr.push_back(int'(reg_address));
      end
      if (!(h_read || h_write) && reg_write) begin
        wr_cyc.push_back(cyc);
        wr_bc.push_back(int'(reg_bytecnt));
        wr_dat.push_back(int'(reg_datao));
      end
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000;
  endfunction

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    gnt_q.delete(); done_q.delete();
    rd_cyc.delete(); rd_bc.delete(); rd_adr.delete();
    wr_cyc.delete(); wr_bc.delete(); wr_dat.delete();
    rv_cyc.delete(); rv_dat.delete();
    wdrd_n = 0;
  endtask

  // Holds m_req for one IDLE cycle; returns in the LOAD (grant) cycle.
  task automatic req(logic w, logic [AW-1:0] a, logic [7:0] l);
    mif.m_req = 1'b1;
    mif.m_wr = w;
    mif.m_address = a;
    mif.m_len = l;
    step();
    mif.m_req = 1'b0;
  endtask

  int g;
  logic [7:0] w0;

  initial begin
    mif.m_req = 1'b0;
    mif.m_wr = 1'b0;
    mif.m_address = '0;
    mif.m_len = '0;
    mif.m_abort = 1'b0;

    // reset state, host visible during reset
    h_read = 1'b1; h_address = 14'd6;
    #12;
    chk("rst_gnt", 32'(mif.m_gnt), 0);
    chk("rst_wdrd", 32'(mif.m_wdata_rd), 0);
    chk("rst_rv", 32'(mif.m_rdata_valid), 0);
    chk("rst_done", 32'(mif.m_done), 0);
    chk("rst_rdata", 32'(mif.m_rdata), 0);
    chk("rst_hrd", 32'(reg_read), 1);
    chk("rst_hadr", 32'(reg_address), 6);
    h_read = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);

    // host write pass-through
    clr();
    h_write = 1'b1; h_address = 14'd5;
    h_bytecnt = 7'd3; h_datao = 8'hA5;
    @(negedge clk);
    chk("h_wr", 32'(reg_write), 1);
    chk("h_adr", 32'(reg_address), 5);
    chk("h_bc", 32'(reg_bytecnt), 3);
    chk("h_dat", 32'(reg_datao), 32'hA5);
    chk("h_av", 32'(reg_addrvalid), 1);
    chk("h_rd", 32'(reg_read), 0);
    step();
    h_write = 1'b0; h_address = '0;
    h_bytecnt = '0; h_datao = '0;
    step(6);
    chk("h_msil", 32'(gnt_q.size() + done_q.size() + wdrd_n), 0);

    // read burst, idle host
    clr();
    req(1'b0, 14'd9, 8'd4);
    step(14);
    g = qat(gnt_q, 0);
    chk("rb_ngnt", 32'(gnt_q.size()), 1);
    chk("rb_nrd", 32'(rd_cyc.size()), 4);
    for (int i = 0; i < 4; i++) begin
      chk("rb_rdcyc", 32'(qat(rd_cyc, i) - g), 32'(1 + 2 * i));
      chk("rb_bc", 32'(qat(rd_bc, i)), 32'(i));
      chk("rb_dat", 32'(qat(rv_dat, i)), 32'(16 + i));
    end
    chk("rb_adr", 32'(qat(rd_adr, 3)), 9);
    chk("rb_done", 32'(qat(done_q, 0) - g), 9);
    chk("rb_ndone", 32'(done_q.size()), 1);

    // write burst interrupted by a 5-cycle host read
    clr();
    w0 = wptr;
    req(1'b1, 14'd2, 8'd3);
    step(2);
    h_read = 1'b1; h_address = 14'd7;
    @(negedge clk);
    chk("wc_hrd", 32'(reg_read), 1);
    chk("wc_hadr", 32'(reg_address), 7);
    chk("wc_hwr", 32'(reg_write), 0);
    step(5);
    h_read = 1'b0; h_address = '0;
    step(10);
    g = qat(gnt_q, 0);
    chk("wc_nwr", 32'(wr_cyc.size()), 3);
    chk("wc_c0", 32'(qat(wr_cyc, 0) - g), 1);
    chk("wc_c1", 32'(qat(wr_cyc, 1) - g), 11);
    chk("wc_c2", 32'(qat(wr_cyc, 2) - g), 12);
    for (int i = 0; i < 3; i++) begin
      chk("wc_bc", 32'(qat(wr_bc, i)), 32'(i));
      chk("wc_dat", 32'(qat(wr_dat, i)), 32'(8'(w0 + 8'hC0 + 8'(i))));
    end
    chk("wc_wdrd", 32'(wdrd_n), 3);
    chk("wc_done", 32'(qat(done_q, 0) - g), 13);

    // zero-length burst
    clr();
    req(1'b0, 14'd1, 8'd0);
    step(6);
    g = qat(gnt_q, 0);
    chk("l0_ngnt", 32'(gnt_q.size()), 1);
    chk("l0_done", 32'(qat(done_q, 0) - g), 1);
    chk("l0_acc", 32'(rd_cyc.size() + wr_cyc.size()), 0);

    // oversize write burst clamps to 128 bytes
    clr();
    req(1'b1, 14'd3, 8'd200);
    step(140);
    g = qat(gnt_q, 0);
    chk("l200_nwr", 32'(wr_cyc.size()), 128);
    chk("l200_bc0", 32'(qat(wr_bc, 0)), 0);
    chk("l200_bcN", 32'(qat(wr_bc, 127)), 127);
    chk("l200_wdrd", 32'(wdrd_n), 128);
    chk("l200_done", 32'(qat(done_q, 0) - g), 129);

    // abort during byte-1 capture of a 4-byte read
    clr();
    req(1'b0, 14'd3, 8'd4);
    step(4);
    mif.m_abort = 1'b1;
    step();
    mif.m_abort = 1'b0;
    step(8);
    chk("ab_nrd", 32'(rd_cyc.size()), 2);
    chk("ab_nrv", 32'(rv_dat.size()), 2);
    chk("ab_rv1", 32'(qat(rv_dat, 1)), 32'h11);
    chk("ab_rvc", 32'(qat(rv_cyc, 1) - qat(gnt_q, 0)), 5);
    chk("ab_ndone", 32'(done_q.size()), 0);
    clr();
    req(1'b0, 14'd3, 8'd1);
    step(6);
    chk("ab_rs_n", 32'(rd_cyc.size()), 1);
    chk("ab_rs_bc", 32'(qat(rd_bc, 0)), 0);
    chk("ab_rs_dn", 32'(done_q.size()), 1);

    // async reset in the middle of a write burst
    clr();
    req(1'b1, 14'd1, 8'd8);
    step(3);
    chk("rm_wdrd1", 32'(mif.m_wdata_rd), 1);
    rst_n = 1'b0;
    #1;
    chk("rm_wdrd0", 32'(mif.m_wdata_rd), 0);
    chk("rm_wr0", 32'(reg_write), 0);
    chk("rm_gnt0", 32'(mif.m_gnt), 0);
    chk("rm_done0", 32'(mif.m_done), 0);
    chk("rm_rv0", 32'(mif.m_rdata_valid), 0);
    chk("rm_rdat0", 32'(mif.m_rdata), 0);
    step(2);
    rst_n = 1'b1;
    step(6);
    clr();
    req(1'b0, 14'd4, 8'd1);
    step(8);
    g = qat(gnt_q, 0);
    chk("rm_ngnt", 32'(gnt_q.size()), 1);
    chk("rm_nwr", 32'(wr_cyc.size()), 0);
    chk("rm_rd", 32'(qat(rd_cyc, 0) - g), 1);
    chk("rm_dat", 32'(qat(rv_dat, 0)), 32'h10);
    chk("rm_done", 32'(qat(done_q, 0) - g), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cw305_reg_arb.md
Name: cw305_reg_arb

Overview:
- Two-master arbiter for the CW305 register bus. It sits between the USB register front-end (host master) and the project register block.
- A second on-chip master (e.g. trace/capture engine) gets multi-byte burst read/write access to the same registers.
- The host cannot be stalled, so it has absolute priority. Internal bursts run only in host-idle gaps and pause/resume byte-by-byte.

Parameters:
- pADDR_WIDTH, 21, full USB address width
- pBYTECNT_SIZE, 7, byte-index width; max burst 2^pBYTECNT_SIZE bytes
- pHOLDOFF, 4, consecutive host-idle cycles required before an internal byte cycle may issue (1..15)

Ports:
- usb_clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- h_address  in  pADDR_WIDTH-pBYTECNT_SIZE  host register address
- h_bytecnt  in  pBYTECNT_SIZE  host byte index
- h_datao  in  8  host write data
- h_read  in  1  host read flag (level)
- h_write  in  1  host write flag
- h_datai  out  8  read data to host; = reg_datai
- m_req  in  1  internal burst request; held until m_gnt
- m_gnt  out  1  one-cycle pulse; burst parameters latched this cycle
- m_wr  in  1  1=write burst, 0=read burst
- m_address  in  pADDR_WIDTH-pBYTECNT_SIZE  burst register address
- m_len  in  pBYTECNT_SIZE+1  burst byte count
- m_wdata  in  8  write byte; FWFT, popped by m_wdata_rd
- m_wdata_rd  out  1  write-byte consume strobe
- m_rdata  out  8  captured read byte
- m_rdata_valid  out  1  one-cycle pulse per read byte
- m_done  out  1  one-cycle pulse at burst completion
- m_abort  in  1  cancel burst in progress
- reg_address  out  pADDR_WIDTH-pBYTECNT_SIZE  to register block
- reg_bytecnt  out  pBYTECNT_SIZE  to register block
- reg_datao  out  8  to register block
- reg_datai  in  8  from register block; valid the cycle after reg_read
- reg_read  out  1  read flag
- reg_write  out  1  write flag
- reg_addrvalid  out  1  high whenever reg_read or reg_write is high

Behaviour:
- Host priority:
  - h_act = h_read|h_write.
  - When h_act=1, the bus mux is combinational host pass-through that same cycle: reg_address, reg_bytecnt, reg_datao, reg_read, reg_write come from the h_* inputs.
  - The mux also selects host whenever the FSM is not issuing.
- Idle counter:
  - 4 bits; cleared when h_act=1, else increments, saturating at pHOLDOFF.
  - hgap = (idle_cnt==pHOLDOFF) & ~h_act.
- FSM states: IDLE, LOAD, ISSUE, CAPT, DONE.
- IDLE -> LOAD: on m_req.
  - In LOAD, m_gnt=1 for 1 cycle.
  - Latch addr, wr, len. len is clamped to 2^pBYTECNT_SIZE.
  - idx<=0.
- LOAD exit:
  - len==0 -> DONE.
  - else -> ISSUE.
- ISSUE, hgap=1, write burst:
  - Drive reg_write=1, reg_datao=m_wdata, reg_bytecnt=idx, m_wdata_rd=1.
  - idx++. If idx==len-1 -> DONE, else stay.
  - One cycle per byte.
- ISSUE, hgap=1, read burst:
  - Drive reg_read=1 for exactly one cycle, reg_bytecnt=idx, reg_address=latched addr.
  - Go to CAPT.
- ISSUE, hgap=0: nothing issued; wait (pause). idx is preserved.
- CAPT:
  - Unconditionally capture m_rdata<=reg_datai, with m_rdata_valid=1 the following cycle.
  - Register blocks latch read data on the reg_read cycle, so capture is valid even if the host becomes active during CAPT.
  - idx++. If idx==len-1 -> DONE, else -> ISSUE.
  - Two cycles per byte minimum.
- DONE: m_done=1 for 1 cycle -> IDLE.
- Back-to-back bursts: m_req may be asserted on the DONE cycle; the next LOAD follows immediately after.
- Abort: m_abort in LOAD, ISSUE or CAPT -> IDLE next cycle.
  - No m_done is generated, and no further strobes.
  - A CAPT in progress still delivers its m_rdata_valid.
- Reset (rst_n low, async, any time including mid-burst):
  - State=IDLE, idle_cnt=0, idx=0.
  - m_gnt, m_wdata_rd, m_rdata_valid, m_done = 0; m_rdata=0.
  - Bus outputs revert to host pass-through.
  - Host accesses during reset still pass through.
- Width rules: idx is pBYTECNT_SIZE+1 bits. reg_bytecnt=idx[pBYTECNT_SIZE-1:0]; no wrap within a burst.

Test Plan:
- Host only: h_write with addr 5, byte 3, data 0xA5 -> reg_write=1, reg_address=5, reg_bytecnt=3, reg_datao=0xA5 same cycle; m_* silent.
- Read burst, idle host: m_len=4, addr 9, reg_datai=0x10+bytecnt -> m_gnt, then 4 reg_read pulses (bytecnt 0..3) spaced 2 cycles; m_rdata 0x10..0x13; m_done 9 cycles after m_gnt (pHOLDOFF met).
- Write burst with host collision: m_len=3; host h_read asserted for 5 cycles after byte 0 -> byte 1 issues exactly pHOLDOFF+1 cycles after h_read drops; bytecnt 0,1,2; exactly 3 m_wdata_rd.
- m_len=0 -> m_gnt, m_done 1 cycle later; no reg_read/reg_write. m_len=200, pBYTECNT_SIZE=7 -> exactly 128 bytes.
- Abort after byte 1 of 4-byte read -> return to IDLE, byte-1 m_rdata_valid delivered, no m_done; next m_req restarts at bytecnt 0.
- rst_n pulsed low mid-write-burst -> all m_* strobes 0 immediately; after release, m_req granted normally.
